// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit owning the HI/LO register pair.
//
// Build option: define MULDIV_DIV_EN to include the restoring divider and the
// DIV/DIVU operations. Without it only MULT/MULTU exist and divide starts are
// dropped in IDLE as if StartE had been low.
//
// Handshake: StartE is accepted only in IDLE with FlushE low. From the accepting
// edge, Busy stays high for WIDTH+1 cycles; while Busy is high, StartE and the
// HI/LO write strobes are dropped and FlushE aborts the operation. Done pulses for
// exactly one cycle, in the cycle HI/LO first show the new result.
//
// Sequencing: IDLE latches operand magnitudes and signs, RUN performs one
// shift-add (multiply) or restoring-subtract (divide) step per cycle for WIDTH
// cycles, and FIX applies the sign correction and writes HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    input  logic             WriteHiW,
    input  logic             WriteLoW,
    input  logic [WIDTH-1:0] ResultW,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic [1:0]       dbg_state_o
);

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0] mag_q, mag_d;
    // Upper accumulator: running product high half, or partial remainder.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    // Lower accumulator: multiplier bits shifting out / product low half,
    // or dividend bits shifting out / quotient bits shifting in.
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             op_ok;
    logic             start_ok;
    logic             is_signed;
    logic             src_a_neg;
    logic             src_b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

`ifdef MULDIV_DIV_EN
    logic             is_div_q, is_div_d;
    logic             div_zero_q, div_zero_d;
    // Raw dividend kept for the divide-by-zero result (HI = original SrcAE).
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_fits;
`endif

    // Which operations this build can launch.
`ifdef MULDIV_DIV_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~OpE[1];
`endif

    // Flush wins over a simultaneous start.
    assign start_ok  = StartE & ~FlushE & op_ok;

    // MULT and DIV (OpE[0] == 0) treat operands as two's complement.
    assign is_signed = ~OpE[0];
    assign src_a_neg = is_signed & SrcAE[WIDTH-1];
    assign src_b_neg = is_signed & SrcBE[WIDTH-1];
    // The most-negative value maps onto itself, which reads correctly as an
    // unsigned magnitude of 2^(WIDTH-1).
    assign abs_a     = src_a_neg ? -SrcAE : SrcAE;
    assign abs_b     = src_b_neg ? -SrcBE : SrcBE;

    // Shift-add step: add the multiplicand when the current multiplier bit is
    // set, then shift the whole {carry, hi, lo} right by one.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : {(WIDTH + 1){1'b0}});
    assign prod      = {acc_hi_q, acc_lo_q};
    assign prod_neg  = -prod;

`ifdef MULDIV_DIV_EN
    // Restoring step: bring in the next dividend bit and try to subtract the
    // divisor; keep the difference only when it does not go negative.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mag_q};
    assign div_fits  = ~div_trial[WIDTH];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accepted start enters RUN, RUN lasts WIDTH steps, FIX one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (FlushE) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values: operand capture, per-step arithmetic, result write.
    always_comb begin
        cnt_d    = cnt_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        mag_d    = mag_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = (state_d != S_IDLE);
        done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        dividend_d = dividend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (WriteHiW) begin
                    hi_d = ResultW;
                end
                if (WriteLoW) begin
                    lo_d = ResultW;
                end
                if (start_ok) begin
                    cnt_d    = '0;
                    neg_a_d  = src_a_neg;
                    neg_b_d  = src_b_neg;
                    acc_hi_d = '0;
`ifdef MULDIV_DIV_EN
                    is_div_d   = OpE[1];
                    div_zero_d = (SrcBE == '0);
                    dividend_d = SrcAE;
                    mag_d      = OpE[1] ? abs_b : abs_a;
                    acc_lo_d   = OpE[1] ? abs_a : abs_b;
`else
                    mag_d    = abs_a;
                    acc_lo_d = abs_b;
`endif
                end
            end
            S_RUN: begin
                if (!FlushE) begin
                    cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        acc_hi_d = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_fits};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
`else
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`endif
                end
            end
            S_FIX: begin
                if (!FlushE) begin
                    done_d = 1'b1;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        if (div_zero_q) begin
                            hi_d = dividend_q;
                            lo_d = '1;
                        end else begin
                            // Quotient truncates toward zero; remainder follows the dividend.
                            // Most-negative / -1 wraps back to most-negative with remainder 0.
                            lo_d = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
                            hi_d = neg_a_q ? -acc_hi_q : acc_hi_q;
                        end
                    end else begin
                        {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : prod;
                    end
`else
                    {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : prod;
`endif
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            mag_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            mag_q    <= mag_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef MULDIV_DIV_EN
    // Divide-only bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= '0;
        end else begin
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            dividend_q <= dividend_d;
        end
    end
`endif

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign HiOut       = hi_q;
    assign LoOut       = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH = 32). The
// reference model predicts Busy/Done/HI/LO cycle by cycle from plain
// arithmetic; directed cases pin literal results, latency and corner cases.
module tb_muldiv_unit;
  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [1:0] RST_OP = DIV_EN ? 2'b11 : 2'b01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         StartE = 1'b0;
  logic [1:0]   OpE = 2'b00;
  logic [W-1:0] SrcAE = '0;
  logic [W-1:0] SrcBE = '0;
  logic         FlushE = 1'b0;
  logic         WriteHiW = 1'b0;
  logic         WriteLoW = 1'b0;
  logic [W-1:0] ResultW = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] HiOut;
  logic [W-1:0] LoOut;
  logic [1:0]   dbg_state;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .StartE(StartE), .OpE(OpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .FlushE(FlushE), .WriteHiW(WriteHiW), .WriteLoW(WriteLoW), .ResultW(ResultW),
    .Busy(Busy), .Done(Done), .HiOut(HiOut), .LoOut(LoOut), .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [2*W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint sa64, sb64;
    logic [2*W-1:0] up;
    int sa, sb, sq, sr;
    case (op)
      2'b00: begin
        sa64 = {{W{a[W-1]}}, a};
        sb64 = {{W{b[W-1]}}, b};
        return sa64 * sb64;
      end
      2'b01: begin
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return up;
      end
      2'b10: begin
        if (b == '0) return {a, {W{1'b1}}};
        if (a == {1'b1, {(W-1){1'b0}}} && b == '1) return {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {W'(sr), W'(sq)};
      end
      default: begin
        if (b == '0) return {a, {W{1'b1}}};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // ---------------- cycle-level model + scoreboard ----------------
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  int           m_left = 0;
  logic [2*W-1:0] m_r;
  logic [2*W-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (FlushE) begin
          m_busy = 1'b0; m_left = 0;
          exp_q.delete();
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_r = exp_q.pop_front();
            m_hi = m_r[2*W-1:W];
            m_lo = m_r[W-1:0];
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end
      end else begin
        if (WriteHiW) m_hi = ResultW;
        if (WriteLoW) m_lo = ResultW;
        if (StartE && !FlushE && (DIV_EN || !OpE[1])) begin
          exp_q.push_back(ref_result(OpE, SrcAE, SrcBE));
          m_left = LAT;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_busy", W'(Busy), W'(m_busy));
      check("cyc_done", W'(Done), W'(m_done));
      check("cyc_hi", HiOut, m_hi);
      check("cyc_lo", LoOut, m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
    @(posedge clk); #1;
    StartE = 1'b0;
  endtask

  // Called just after the accepting edge; bounded wait for Done.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = Busy ? 1 : 0;
    while (!Done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (Busy) bcnt++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int cyc, bcnt;
    start_op(op, a, b);
    wait_done(cyc, bcnt);
    check({name, "_done_edge"}, W'(cyc), W'(LAT));
    check({name, "_busy_cycles"}, W'(bcnt), W'(LAT));
    check({name, "_hi"}, HiOut, eh);
    check({name, "_lo"}, LoOut, el);
  endtask

  task automatic pin(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    check({name, "_hi"}, got[2*W-1:W], exp[2*W-1:W]);
    check({name, "_lo"}, got[W-1:0], exp[W-1:0]);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return {1'b1, {(W-1){1'b0}}};
      4: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc, bcnt;
    logic seen;

    // Model pins against hand-computed values.
    pin("model_mult", ref_result(2'b00, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
    pin("model_multu", ref_result(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    pin("model_divu", ref_result(2'b11, 32'd100, 32'd7), 64'h00000002_0000000E);
    pin("model_div", ref_result(2'b10, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    pin("model_div0", ref_result(2'b11, 32'h12345678, 32'd0), 64'h12345678_FFFFFFFF);
    pin("model_ovf", ref_result(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(Busy), '0);
    check("rst_done", W'(Done), '0);
    check("rst_hi", HiOut, '0);
    check("rst_lo", LoOut, '0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Signed multiply with latency.
    run_op("mult", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    @(posedge clk); #1;
    check("done_pulse_width", W'(Done), '0);

`ifdef MULDIV_DIV_EN
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", 2'b11, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
`else
    // Divide starts are ignored in this build.
    @(posedge clk); #1;
    WriteHiW = 1'b1; WriteLoW = 1'b0; ResultW = 32'h55550000;
    @(posedge clk); #1;
    WriteHiW = 1'b0; WriteLoW = 1'b1; ResultW = 32'h00005555;
    @(posedge clk); #1;
    WriteLoW = 1'b0;
    StartE = 1'b1; OpE = 2'b10; SrcAE = 32'd100; SrcBE = 32'd7;
    @(posedge clk); #1;
    StartE = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (Busy || Done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("nodiv_busy", W'(seen), '0);
    check("nodiv_hi", HiOut, 32'h55550000);
    check("nodiv_lo", LoOut, 32'h00005555);
`endif

    // Write in IDLE alongside a start: both happen.
    @(posedge clk); #1;
    WriteLoW = 1'b1; ResultW = 32'h00001234;
    StartE = 1'b1; OpE = 2'b01; SrcAE = 32'd6; SrcBE = 32'd9;
    @(posedge clk); #1;
    WriteLoW = 1'b0; StartE = 1'b0;
    check("wr_start_lo", LoOut, 32'h00001234);
    check("wr_start_busy", W'(Busy), W'(1));
    // Writes while busy are dropped.
    WriteHiW = 1'b1; ResultW = 32'hDEADBEEF;
    @(posedge clk); #1;
    WriteHiW = 1'b0;
    wait_done(cyc, bcnt);
    check("wr_start_hi", HiOut, 32'd0);
    check("wr_start_res", LoOut, 32'd54);

    // Preload HI, flush a MULTU mid-flight.
    @(posedge clk); #1;
    WriteHiW = 1'b1; ResultW = 32'h0000AAAA;
    @(posedge clk); #1;
    WriteHiW = 1'b0;
    check("mthi", HiOut, 32'h0000AAAA);
    start_op(2'b01, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) begin @(posedge clk); #1; end
    FlushE = 1'b1;
    @(posedge clk); #1;
    FlushE = 1'b0;
    check("flush_busy", W'(Busy), '0);
    seen = 1'b0;
    repeat (40) begin
      if (Done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_done", W'(seen), '0);
    check("flush_hi", HiOut, 32'h0000AAAA);

    // Second start during Busy has no effect.
    start_op(2'b01, 32'd3, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    StartE = 1'b1; OpE = 2'b00; SrcAE = 32'hFFFFFFFF; SrcBE = 32'd2;
    @(posedge clk); #1;
    StartE = 1'b0;
    wait_done(cyc, bcnt);
    check("stall_done", W'(Done), W'(1));
    check("stall_hi", HiOut, 32'd0);
    check("stall_lo", LoOut, 32'd21);

    // Reset in the middle of an operation.
    start_op(RST_OP, 32'd1000, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", W'(Busy), '0);
    check("midrst_done", W'(Done), '0);
    check("midrst_hi", HiOut, '0);
    check("midrst_lo", LoOut, '0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // Randomized traffic checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      StartE   = ($urandom_range(0, 5) == 0);
      OpE      = 2'($urandom_range(0, 3));
      SrcAE    = pick();
      SrcBE    = pick();
      FlushE   = ($urandom_range(0, 63) == 0);
      WriteHiW = ($urandom_range(0, 9) == 0);
      WriteLoW = ($urandom_range(0, 9) == 0);
      ResultW  = W'($urandom);
      @(posedge clk); #1;
    end
    StartE = 1'b0; FlushE = 1'b0; WriteHiW = 1'b0; WriteLoW = 1'b0;
    repeat (LAT + 5) begin @(posedge clk); #1; end
    check("drain_idle", W'(Busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
